// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and frame length.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Bit periods per frame: start + data + optional parity + stop bits.
  function automatic int FRAME_LEN(input int data_bits, input int parity_en,
                                   input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side valid/ready word handshake into the UART transmitter queue.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with occupancy count; shared by the UART transmit and receive paths.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  import uart_pkg::*;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: queued words are framed (start, data LSB first,
// optional parity, 1-2 stop bits) and shifted out one bit per tx_en strobe.
module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  uart_tx_frame_if.slave                in_if,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  import uart_pkg::*;

  localparam int            IW        = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS);
  localparam logic          ODD_FLIP  = (PARITY_ODD == PAR_ODD);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        bit_idx_q;
  logic [1:0]           stop_cnt_q;
  logic                 parity_q;
  logic                 tx_q;

  logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 frame_done;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ODD_FLIP;
  endfunction

  assign in_if.data_ready = !fifo_full;
  assign fifo_push        = in_if.data_valid && !fifo_full;
  assign frame_done       = (state_q == STOP) && (stop_cnt_q >= STOP_LAST);
  // The queue head is consumed only on a strobe that starts a new frame.
  assign fifo_pop         = tx_en && !fifo_empty && ((state_q == IDLE) || frame_done);

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (in_if.data_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
    end else if (tx_en) begin
      if (fifo_pop) begin
        // Parity is fixed at load time so shifting does not disturb it.
        shift_q  <= fifo_head;
        parity_q <= calc_parity(fifo_head);
        tx_q     <= 1'b0;
        state_q  <= START;
      end else begin
        unique case (state_q)
          IDLE: begin
            tx_q <= 1'b1;
          end
          START: begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= IW'(1);
            state_q   <= DATA;
          end
          DATA: begin
            if (bit_idx_q < LAST_BIT) begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + IW'(1);
            end else if (PARITY_EN != 0) begin
              tx_q    <= parity_q;
              state_q <= PARITY;
            end else begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 2'd1;
              state_q    <= STOP;
            end
          end
          PARITY: begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 2'd1;
            state_q    <= STOP;
          end
          STOP: begin
            tx_q <= 1'b1;
            if (stop_cnt_q < STOP_LAST) stop_cnt_q <= stop_cnt_q + 2'd1;
            else                        state_q    <= IDLE;
          end
          default: begin
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four parameter variants, expected line bits and
// busy-run lengths queued at stimulus time and checked by an independent monitor.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tx_en0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
  uart_tx_frame_if #(.DATA_BITS(5)) if3 ();

  wire       tx0, tx1, tx2, tx3, bz0, bz1, bz2, bz3;
  wire [2:0] cnt0, cnt1, cnt2, cnt3;
  wire [3:0] tx_w   = {tx3, tx2, tx1, tx0};
  wire [3:0] busy_w = {bz3, bz2, bz1, bz0};

  uart_tx_frame u0 (.clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .in_if(if0),
                    .tx(tx0), .busy(bz0), .fifo_count(cnt0));
  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .in_if(if1),
    .tx(tx1), .busy(bz1), .fifo_count(cnt1));
  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en0), .in_if(if2),
    .tx(tx2), .busy(bz2), .fifo_count(cnt2));
  uart_tx_frame #(.DATA_BITS(5)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_en(1'b1), .in_if(if3),
    .tx(tx3), .busy(bz3), .fifo_count(cnt3));

  logic exp_q  [4][$];
  int   busy_q [4][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // bits is written in transmission order, first bit in the highest position.
  task automatic expect_frame(input int d, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) exp_q[d].push_back(bits[len-1-i]);
  endtask

  task automatic run_periods(input int n);
    for (int p = 0; p < n; p++) begin
      tx_en0 = 1'b1;
      @(posedge clk); #1;
      tx_en0 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
    end
  endtask

  task automatic push0(input logic [7:0] w);
    if0.data_in = w; if0.data_valid = 1'b1;
    @(posedge clk); #1;
    if0.data_valid = 1'b0;
  endtask

  // Monitor
  logic [3:0] en_prev;
  logic [3:0] tx_prev;
  logic       rst_prev = 1'b0;
  int         run [4] = '{0, 0, 0, 0};

  always @(posedge clk) en_prev <= {1'b1, tx_en0, tx_en0, tx_en0};

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (!rst_n) begin
        run[d] = 0;
      end else begin
        if (busy_w[d]) begin
          run[d]++;
          if (en_prev[d]) begin
            if (exp_q[d].size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_bit dut%0d: got tx=%0b, expected no frame", d, tx_w[d]);
            end else begin
              check($sformatf("line_bit dut%0d", d), tx_w[d], exp_q[d].pop_front());
            end
          end
        end else begin
          check($sformatf("idle_high dut%0d", d), tx_w[d], 1'b1);
          if (run[d] > 0) begin
            if (busy_q[d].size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_busy dut%0d: got run of %0d cycles, expected none", d, run[d]);
            end else begin
              check($sformatf("busy_len dut%0d", d), run[d], busy_q[d].pop_front());
            end
            run[d] = 0;
          end
        end
        if (rst_prev && !en_prev[d])
          check($sformatf("tx_stable dut%0d", d), tx_w[d], tx_prev[d]);
      end
    end
    tx_prev  = tx_w;
    rst_prev = rst_n;
  end

  logic r;
  logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [9:0] frames [4] = '{10'b0_10001000_1, 10'b0_01000100_1,
                             10'b0_11001100_1, 10'b0_00100010_1};

  initial begin
    rst_n = 1'b0; tx_en0 = 1'b0;
    if0.data_valid = 1'b0; if1.data_valid = 1'b0; if2.data_valid = 1'b0; if3.data_valid = 1'b0;
    if0.data_in = '0; if1.data_in = '0; if2.data_in = '0; if3.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", bz0, 1'b0);
    check("rst_ready", if0.data_ready, 1'b1);
    check("rst_count", cnt0, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 0xA5 on 8N1, 8E1, 8O2; 5'b10011 on 5N1 with strobe tied high
    expect_frame(0, 16'(10'b0_10100101_1), 10);    busy_q[0].push_back(40);
    expect_frame(1, 16'(11'b0_10100101_0_1), 11);  busy_q[1].push_back(44);
    expect_frame(2, 16'(12'b0_10100101_1_11), 12); busy_q[2].push_back(48);
    expect_frame(3, 16'(7'b0_11001_1), 7);         busy_q[3].push_back(7);
    if0.data_in = 8'hA5; if1.data_in = 8'hA5; if2.data_in = 8'hA5; if3.data_in = 5'b10011;
    if0.data_valid = 1'b1; if1.data_valid = 1'b1; if2.data_valid = 1'b1; if3.data_valid = 1'b1;
    @(posedge clk); #1;
    if0.data_valid = 1'b0; if1.data_valid = 1'b0; if2.data_valid = 1'b0; if3.data_valid = 1'b0;
    run_periods(14);

    // Back-to-back 0x00, 0xFF: one continuous busy run of 20 periods
    expect_frame(0, 16'(10'b0_00000000_1), 10);
    expect_frame(0, 16'(10'b0_11111111_1), 10);
    busy_q[0].push_back(80);
    push0(8'h00);
    push0(8'hFF);
    run_periods(22);

    // Fill the queue with the strobe stopped; fifth word must be refused
    if0.data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if0.data_in = words[i];
      @(negedge clk); r = if0.data_ready;
      check($sformatf("fill_ready w%0d", i), r, (i < 4) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      if (i < 4) expect_frame(0, 16'(frames[i]), 10);
    end
    @(negedge clk);
    check("full_count", cnt0, 3'd4);
    check("full_ready", if0.data_ready, 1'b0);
    @(posedge clk); #1;
    if0.data_valid = 1'b0;
    busy_q[0].push_back(160);
    tx_en0 = 1'b1;
    @(posedge clk); #1;
    tx_en0 = 1'b0;
    @(negedge clk);
    check("pop_count", cnt0, 3'd3);
    check("pop_ready", if0.data_ready, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    run_periods(42);

    // Reset in the middle of 0x3C with two more words queued
    expect_frame(0, 16'(10'b0_00111100_1), 10);
    push0(8'h3C); push0(8'h81); push0(8'h7E);
    run_periods(4);
    check("mid_count", cnt0, 3'd2);
    check("mid_busy", bz0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_tx", tx0, 1'b1);
    check("abort_busy", bz0, 1'b0);
    check("abort_count", cnt0, 3'd0);
    check("abort_ready", if0.data_ready, 1'b1);
    exp_q[0].delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    run_periods(12);

    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("bits_left dut%0d", d), exp_q[d].size(), 0);
      check($sformatf("runs_left dut%0d", d), busy_q[d].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Configurable data width, optional parity and 1 or 2 stop bits. Small input FIFO with a valid/ready handshake allows back-to-back frames. Bit timing comes from an external one-cycle baud strobe (tx_en) supplied by the shared baud generator.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9; sent LSB first
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, legal 1 or 2
FIFO_DEPTH, 4, input FIFO entries, power of two, >=2

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_en  in  1  baud strobe, one clk cycle high per bit period
data_in  in  DATA_BITS  byte/word to queue
data_valid  in  1  producer offers data_in
data_ready  out  1  FIFO not full; transfer when data_valid && data_ready
tx  out  1  serial line, idle high, registered
busy  out  1  high while a frame is on the line (state != IDLE)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, data_ready=1, fifo_count=0, FIFO flushed, state IDLE, counters 0. Reset mid-frame aborts the frame; tx goes to 1 immediately.
- Frame length F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bit periods. Each bit is held from one tx_en pulse to the next.
- tx changes only in cycles where tx_en=1.
- States:
  - IDLE: tx=1. On tx_en with FIFO non-empty: pop head into shift register, tx<=0, go to START.
  - START: on tx_en: tx<=data[0], bit_idx<=1, go to DATA.
  - DATA: on tx_en: if bit_idx<DATA_BITS, tx<=data[bit_idx] and bit_idx++. Otherwise go to PARITY (tx<=parity) if PARITY_EN, else go to STOP (tx<=1, stop_cnt<=1).
  - PARITY: on tx_en: tx<=1, stop_cnt<=1, go to STOP.
  - STOP: on tx_en:
    - If stop_cnt<STOP_BITS: tx<=1, stop_cnt++.
    - Else, if FIFO non-empty: pop, tx<=0, go to START (back-to-back, no idle gap).
    - Else: go to IDLE (tx stays 1).
- Parity = XOR of the data bits, inverted when PARITY_ODD=1. Computed at pop time and held.
- busy = (state != IDLE). It is low in the cycle after the final stop period ends with no queued data.
- FIFO:
  - Push when data_valid && data_ready.
  - Pop only in the cycle the FSM consumes an entry.
  - Simultaneous push and pop when full: the push is refused, because data_ready is computed from the registered count before the pop.
  - Simultaneous push and pop when empty is impossible, since a pop requires non-empty.
  - fifo_count updates one cycle after the push or pop; pointers wrap modulo FIFO_DEPTH.
- data_ready = (fifo_count != FIFO_DEPTH).
- Pushes while busy are allowed and do not disturb the frame in progress.
- tx_en held high continuously is legal: one bit per clk cycle.
- data_in bits above DATA_BITS do not exist; width is exact.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constant FRAME_LEN function of the parameters
  - parity-mode constants (PAR_EVEN=0, PAR_ODD=1)
- One sub-module, uart_fifo (parametrised WIDTH, DEPTH; push/pop/full/empty/count, async active-low reset). The same sub-module is reusable by a future uart_rx.
- The FSM and serialiser stay in uart_tx_frame.

Test Plan:
- Defaults (8N1), tx_en every 4 clk, push 0xA5 -> tx per bit period: 0,1,0,1,0,0,1,0,1,1; busy high for exactly 10 tx_en periods, then low; tx=1 throughout idle.
- PARITY_EN=1, PARITY_ODD=0, push 0xA5 -> parity bit 0 after the data bits. With PARITY_ODD=1 -> parity bit 1. With STOP_BITS=2 -> two 1 periods before idle; frame is 12 periods.
- Push 0x00 then 0xFF back-to-back -> the second start bit immediately follows the first stop bit; 20 contiguous bit periods; busy never drops between frames.
- FIFO_DEPTH=4, tx_en held low, push 5 words with data_valid=1 -> data_ready low after the 4th accept, fifo_count=4, 5th word not accepted. After the first pop: data_ready=1, count=3.
- Assert rst_n=0 mid-DATA of 0x3C with 2 words queued -> tx=1 and busy=0 immediately, fifo_count=0. After release, no frame starts without a new push.
- DATA_BITS=5, tx_en tied high, push 5'b10011 -> tx sequence 0,1,1,0,0,1,1 on consecutive cycles, then idle.
